sync_debounce_d: RTL and testbench

- Input-conditioning stage directly upstream of the D flip-flop.
- Takes an asynchronous, possibly bouncing level (switch or external pin), synchronises it to clk and filters out short pulses.
- Produces a clean level that drives the flop's D input, plus one-cycle rise/fall strobes.
- Keeps a saturating count of accepted transitions for debug.

---
 rtl/sync_debounce_d.sv | 52 +++++
 tb/tb_sync_debounce_d.sv | 122 ++++++++++++
 2 files changed

// File: rtl/sync_debounce_d.sv
// sync_debounce_d: synchronises and debounces an async level, emitting edge strobes and a saturating transition count
module sync_debounce_d #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             din_async,
  output logic             dout,
  output logic             rise,
  output logic             fall,
  output logic             busy,
  output logic [CNT_W-1:0] changes
);
  localparam int CW = DEBOUNCE_CYCLES > 1 ? $clog2(DEBOUNCE_CYCLES) : 1;
  typedef enum logic {STABLE, CHECK} state_t;
  state_t state, state_n;
  logic [SYNC_STAGES-1:0] sync;
  logic [CW-1:0] cnt, cnt_n;
  logic s, diff, accept;
  assign s = sync[SYNC_STAGES-1];
  assign busy = state == CHECK;
  // plain shift chain; no logic between stages so metastability can settle
  always_ff @(posedge clk or negedge reset)
    if (!reset) sync <= '0;
    else sync <= {sync[SYNC_STAGES-2:0], din_async};
  // a transition is accepted once s has differed from dout for DEBOUNCE_CYCLES edges; any reversal restarts from zero
  always_comb begin
    diff    = s != dout;
    accept  = diff && (state == STABLE ? DEBOUNCE_CYCLES == 1 : cnt == CW'(DEBOUNCE_CYCLES - 1));
    state_n = diff && !accept ? CHECK : STABLE;
    cnt_n   = state_n == CHECK ? cnt + CW'(1) : '0;
  end
  // state, clean level, strobes and saturating counter all register together
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state   <= STABLE;
      cnt     <= '0;
      dout    <= 1'b0;
      rise    <= 1'b0;
      fall    <= 1'b0;
      changes <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      dout  <= accept ? s : dout;
      rise  <= accept & s;
      fall  <= accept & ~s;
      if (accept && changes != '1) changes <= changes + CNT_W'(1);
    end
endmodule

// File: tb/tb_sync_debounce_d.sv
// tb_sync_debounce_d: random and directed stimulus against a run-length reference model for two configurations
module tb_sync_debounce_d;
  logic clk, reset, din_async;
  logic dout0, rise0, fall0, busy0;
  logic [7:0] changes0;
  logic dout1, rise1, fall1, busy1;
  logic [1:0] changes1;
  int checks, errors;
  int ss[2] = '{2, 3};
  int dd[2] = '{4, 1};
  int mx[2] = '{255, 3};
  bit hist[2][8];
  bit mdout[2], mrise[2], mfall[2];
  int mrun[2], mchg[2];

  sync_debounce_d dut0 (.clk(clk), .reset(reset), .din_async(din_async), .dout(dout0), .rise(rise0),
                        .fall(fall0), .busy(busy0), .changes(changes0));
  sync_debounce_d #(.SYNC_STAGES(3), .DEBOUNCE_CYCLES(1), .CNT_W(2)) dut1 (
    .clk(clk), .reset(reset), .din_async(din_async), .dout(dout1), .rise(rise1),
    .fall(fall1), .busy(busy1), .changes(changes1));

  initial clk = 1'b1;
  always #10 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      for (int j = 0; j < 8; j++) hist[i][j] = 1'b0;
      mdout[i] = 1'b0; mrise[i] = 1'b0; mfall[i] = 1'b0; mrun[i] = 0; mchg[i] = 0;
    end
  endtask

  // the level seen S edges ago must disagree with dout for D consecutive edges to be accepted
  task automatic model_step(input bit d);
    for (int i = 0; i < 2; i++) begin
      bit s;
      s = hist[i][ss[i]-1];
      for (int j = 7; j > 0; j--) hist[i][j] = hist[i][j-1];
      hist[i][0] = d;
      mrun[i] = s != mdout[i] ? mrun[i] + 1 : 0;
      mrise[i] = 1'b0;
      mfall[i] = 1'b0;
      if (mrun[i] == dd[i]) begin
        mdout[i] = s;
        mrise[i] = s;
        mfall[i] = !s;
        mrun[i] = 0;
        if (mchg[i] < mx[i]) mchg[i]++;
      end
    end
  endtask

  task automatic check_all(input string ph);
    check({ph, ".dout0"}, 32'(dout0), 32'(mdout[0]));
    check({ph, ".rise0"}, 32'(rise0), 32'(mrise[0]));
    check({ph, ".fall0"}, 32'(fall0), 32'(mfall[0]));
    check({ph, ".busy0"}, 32'(busy0), 32'(mrun[0] > 0));
    check({ph, ".changes0"}, 32'(changes0), 32'(mchg[0]));
    check({ph, ".dout1"}, 32'(dout1), 32'(mdout[1]));
    check({ph, ".rise1"}, 32'(rise1), 32'(mrise[1]));
    check({ph, ".fall1"}, 32'(fall1), 32'(mfall[1]));
    check({ph, ".busy1"}, 32'(busy1), 32'(mrun[1] > 0));
    check({ph, ".changes1"}, 32'(changes1), 32'(mchg[1]));
    check({ph, ".excl"}, 32'((rise0 & fall0) | (rise1 & fall1)), 32'(0));
  endtask

  task automatic cycle(input string ph, input bit d, input bit r);
    @(negedge clk);
    din_async = d;
    reset = r;
    if (!r) model_reset();
    @(posedge clk);
    if (r) model_step(d);
    #1 check_all(ph);
  endtask

  task automatic async_reset(input string ph);
    #4 reset = 1'b0;
    model_reset();
    #1 check_all(ph);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset = 1'b0;
    din_async = 1'b1;
    model_reset();
    #5 check_all("rst");
    repeat (10) cycle("rel", 1'b1, 1'b1);
    repeat (10) cycle("fall", 1'b0, 1'b1);
    repeat (10) cycle("rise", 1'b1, 1'b1);
    repeat (10) cycle("fall2", 1'b0, 1'b1);
    repeat (3) cycle("glitch", 1'b1, 1'b1);
    repeat (10) cycle("glitch", 1'b0, 1'b1);
    repeat (4) cycle("midchk", 1'b1, 1'b1);
    async_reset("midchk.rst");
    repeat (2) cycle("inrst", 1'b1, 1'b0);
    repeat (10) cycle("requal", 1'b1, 1'b1);
    for (int n = 0; n < 5; n++) repeat (10) cycle("sat", n[0], 1'b1);
    for (int n = 0; n < 60; n++) begin
      bit d;
      int len;
      d = 1'($urandom_range(0, 1));
      len = $urandom_range(1, 8);
      repeat (len) cycle("rand", d, 1'b1);
      if ($urandom_range(0, 9) == 0) begin
        async_reset("rand.rst");
        repeat (2) cycle("rand.inrst", d, 1'b0);
      end
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
